mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage reader of the EX/MEM pipeline register outputs.
- Turns the latched ALU result (address), store data, MemWrite, load flag and DMType into a req/ack data-bus transaction, with byte-lane formatting on stores and sign/zero extension on loads.
- Raises `stall_out` toward the hazard unit so EX/MEM and all earlier stages hold until the access completes.
- Supplies the load result and a bus-error flag to the MEM/WB register.

Parameters:
- TIMEOUT_CYCLES, 16, number of BUSY cycles without `bus_ack_i` before the access is aborted; 0 disables the timeout.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX/MEM slot holds a real instruction (not a bubble).
- addr_in  in  32  `alures_out` from EX/MEM.
- wdata_in  in  32  `rs2_data_out` from EX/MEM (already forwarded).
- mem_write_in  in  1  `MemWrite_out` from EX/MEM.
- is_load_in  in  1  WDSel selects memory data; decoded at top level.
- dm_type_in  in  3  `DMType_out` from EX/MEM.
- stall_out  out  1  hold EX/MEM and upstream stages.
- bus_req_o  out  1  request strobe; held until ack.
- bus_we_o  out  1  1 = write.
- bus_addr_o  out  32  word-aligned address, {addr[31:2],2'b00}.
- bus_wdata_o  out  32  lane-replicated store data.
- bus_wstrb_o  out  4  byte strobes.
- bus_rdata_i  in  32  read data, valid when `bus_ack_i`=1.
- bus_ack_i  in  1  one-cycle completion pulse.
- load_data_out  out  32  extended load result; valid in DONE.
- done_out  out  1  one-cycle pulse when an access completes.
- bus_err_out  out  1  timeout abort; valid with `done_out`.

Behaviour:
- DMType encodings: 000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned. Other codes are treated as word.
- An access is `in_valid & (mem_write_in | is_load_in)`. If both flags are set, the access is a store.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: when an access is present, `stall_out`=1 combinationally and the FSM goes to BUSY. The bus_* outputs are registered at this edge.
  - BUSY: `bus_req_o`=1 and all bus outputs are stable; `stall_out`=1. On `bus_ack_i`: capture the extended rdata (loads) and go to DONE. On a timeout: `bus_err_out`=1, `load_data_out`=0, go to DONE.
  - DONE: `stall_out`=0, `done_out`=1, `bus_req_o`=0. Always returns to IDLE. EX/MEM advances on this edge, so the same instruction never re-triggers.
- Minimum latency, with ack in the first BUSY cycle: 2 stall cycles, then 1 DONE cycle.
- Timeout counter:
  - Clears on entry to BUSY.
  - Aborts when the count reaches TIMEOUT_CYCLES-1 with no ack.
  - If ack and timeout occur in the same cycle, ack wins and there is no error.
- Store formatting:
  - word: wdata, strb 1111.
  - half: {2{wdata[15:0]}}, strb 0011 shifted left by 2*addr[1].
  - byte: {4{wdata[7:0]}}, strb 0001 shifted left by addr[1:0].
- Load extraction:
  - Select the byte at addr[1:0] or the half at addr[1].
  - Sign-extend for byte/half; zero-extend for the unsigned types.
- `bus_ack_i` outside BUSY is ignored.
- `in_valid`=0 or a non-memory instruction: IDLE, `stall_out`=0, no bus activity.
- Reset:
  - Reset values: all outputs 0, state IDLE, counter 0.
  - Asserting `rst` mid-transaction drops `bus_req_o` immediately, with no completion pulse.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- With the macro:
  - Adds output `misalign_out` (1 bit, reset 0).
  - A half at odd addr[0], or a word with addr[1:0]≠0, issues no bus request. The FSM goes IDLE→DONE with 1 stall cycle; `misalign_out`=1 with `done_out`, and `load_data_out`=0.
- Without the macro:
  - No port.
  - Halves use addr[1] only; words ignore addr[1:0]. The access always proceeds.

Decomposition:
- Package mem_pkg: DMType localparams, FSM state encoding, strobe constants (STRB_WORD, STRB_HALF, STRB_BYTE).
- One combinational sub-module, mem_lane_align: store replication and strobe generation plus load extraction and extension. It is reused by the testbench reference model.

Test Plan:
1. sw: addr=0x1004, wdata=0xDEADBEEF, ack after 2 BUSY cycles -> `bus_addr_o`=0x1004, strb=1111, `stall_out` high for 3 cycles, then `done_out`=1, `bus_err_out`=0.
2. sb: addr=0x2003, wdata=0x000000A5 -> `bus_wdata_o`=0xA5A5A5A5, strb=1000, `bus_addr_o`=0x2000.
3. lb at addr=0x3001 with rdata=0x12348056 -> `load_data_out`=0xFFFFFF80. lhu at addr=0x3002, same rdata -> 0x00001234.
4. Load with no ack, TIMEOUT_CYCLES=4 -> exactly 4 BUSY cycles, then DONE with `bus_err_out`=1 and `load_data_out`=0. Repeat with ack on the 4th cycle -> no error.
5. `rst` low during BUSY -> `bus_req_o`=0 at once, and `stall_out`/`done_out`=0. After release, the next access runs normally; a back-to-back load then store complete with no lost or duplicate request.
6. MEM_MISALIGN_TRAP_EN defined, lw at addr=0x4002 -> no `bus_req_o`, 1 stall cycle, then `misalign_out`=1 and `done_out`=1. Macro undefined -> request issued to 0x4000 with strb=1111.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM-stage data-bus access unit.
//   - DMType encodings (word / half / half-unsigned / byte / byte-unsigned)
//   - FSM state encoding for mem_access_unit
//   - base byte-strobe patterns, shifted into lane position by mem_lane_align
package mem_pkg;

    localparam logic [2:0] DM_WORD  = 3'b000;
    localparam logic [2:0] DM_HALF  = 3'b001;
    localparam logic [2:0] DM_HALFU = 3'b010;
    localparam logic [2:0] DM_BYTE  = 3'b011;
    localparam logic [2:0] DM_BYTEU = 3'b100;

    localparam logic [3:0] STRB_WORD = 4'b1111;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_BYTE = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane formatting.
//   Store side: replicates store data across all lanes and builds byte strobes.
//   Load side : selects the byte/half addressed by addr_lo_i and extends it.
// Ports:
//   dm_type_i  DMType (unknown codes behave as word)
//   addr_lo_i  address bits [1:0]
//   wdata_i    raw store data          -> wdata_o  lane-replicated store data
//   rdata_i    raw bus read data       -> rdata_o  extended load result
//   wstrb_o    byte strobes
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  dm_type_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] rdata_o
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
    end

    always_comb begin
        wdata_o = wdata_i;
        wstrb_o = STRB_WORD;
        rdata_o = rdata_i;
        case (dm_type_i)
            DM_HALF, DM_HALFU: begin
                wdata_o = {2{wdata_i[15:0]}};
                wstrb_o = STRB_HALF << {addr_lo_i[1], 1'b0};
                rdata_o = (dm_type_i == DM_HALF) ? {{16{half_sel[15]}}, half_sel}
                                                 : {16'h0000, half_sel};
            end
            DM_BYTE, DM_BYTEU: begin
                wdata_o = {4{wdata_i[7:0]}};
                wstrb_o = STRB_BYTE << addr_lo_i;
                rdata_o = (dm_type_i == DM_BYTE) ? {{24{byte_sel[7]}}, byte_sel}
                                                 : {24'h000000, byte_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-bus sequencer fed by the EX/MEM register.
// Converts a load/store in EX/MEM into one req/ack bus transaction, holds the
// pipeline via stall_out until it completes, then pulses done_out for one
// cycle with the extended load data and a timeout error flag.
// Ports:
//   clk, rst (async, active low)
//   in_valid, addr_in, wdata_in, mem_write_in, is_load_in, dm_type_in  EX/MEM inputs
//   stall_out                                                          to hazard unit
//   bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o          bus request
//   bus_rdata_i, bus_ack_i                                             bus response
//   load_data_out, done_out, bus_err_out                               to MEM/WB
//   misalign_out                                    only with MEM_MISALIGN_TRAP_EN
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned half/word accesses
// complete without a bus request and flag misalign_out).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no access in flight; an access stalls and is launched
// BUSY  | bus_req_o held, waiting for ack or timeout
// DONE  | one-cycle completion; EX/MEM advances on the exit edge
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [31:0]       wdata_in,
    input  logic              mem_write_in,
    input  logic              is_load_in,
    input  logic [2:0]        dm_type_in,
    output logic              stall_out,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [31:0]       bus_wdata_o,
    output logic [3:0]        bus_wstrb_o,
    input  logic [31:0]       bus_rdata_i,
    input  logic              bus_ack_i,
    output logic [31:0]       load_data_out,
    output logic              done_out,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              misalign_out,
`endif
    output logic              bus_err_out
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    mem_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             is_load_q;
    logic [2:0]       dm_q;
    logic [1:0]       addr_lo_q;

    logic             access;
    logic             in_idle;
    logic [2:0]       align_dm;
    logic [1:0]       align_lo;
    logic [31:0]      fmt_wdata;
    logic [3:0]       fmt_wstrb;
    logic [31:0]      ext_rdata;

    assign access  = in_valid & (mem_write_in | is_load_in);
    assign in_idle = (state_q == ST_IDLE);

    // Store formatting uses the live EX/MEM fields at launch; load extraction
    // uses the copies latched at launch.
    assign align_dm = in_idle ? dm_type_in    : dm_q;
    assign align_lo = in_idle ? addr_in[1:0]  : addr_lo_q;

    mem_lane_align u_lane_align (
        .dm_type_i (align_dm),
        .addr_lo_i (align_lo),
        .wdata_i   (wdata_in),
        .rdata_i   (bus_rdata_i),
        .wdata_o   (fmt_wdata),
        .wstrb_o   (fmt_wstrb),
        .rdata_o   (ext_rdata)
    );

    // Gated by rst so the hazard unit sees no stall while reset is held.
    assign stall_out = rst & ((in_idle & access) | (state_q == ST_BUSY));

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned;
    logic misalign_q;

    always_comb begin
        case (dm_type_in)
            DM_HALF, DM_HALFU: misaligned = addr_in[0];
            DM_BYTE, DM_BYTEU: misaligned = 1'b0;
            default:           misaligned = (addr_in[1:0] != 2'b00);
        endcase
    end

    assign misalign_out = misalign_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            is_load_q     <= 1'b0;
            dm_q          <= DM_WORD;
            addr_lo_q     <= 2'b00;
            bus_req_o     <= 1'b0;
            bus_we_o      <= 1'b0;
            bus_addr_o    <= '0;
            bus_wdata_o   <= '0;
            bus_wstrb_o   <= '0;
            load_data_out <= '0;
            done_out      <= 1'b0;
            bus_err_out   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (access) begin
`ifdef MEM_MISALIGN_TRAP_EN
                        if (misaligned) begin
                            state_q       <= ST_DONE;
                            done_out      <= 1'b1;
                            misalign_q    <= 1'b1;
                            load_data_out <= '0;
                        end else
`endif
                        begin
                            state_q     <= ST_BUSY;
                            cnt_q       <= '0;
                            is_load_q   <= ~mem_write_in;
                            dm_q        <= dm_type_in;
                            addr_lo_q   <= addr_in[1:0];
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= mem_write_in;
                            bus_addr_o  <= {addr_in[ADDR_W-1:2], 2'b00};
                            bus_wdata_o <= fmt_wdata;
                            bus_wstrb_o <= fmt_wstrb;
                        end
                    end
                end
                ST_BUSY: begin
                    // Ack takes priority over a timeout in the same cycle.
                    if (bus_ack_i) begin
                        state_q       <= ST_DONE;
                        bus_req_o     <= 1'b0;
                        done_out      <= 1'b1;
                        load_data_out <= is_load_q ? ext_rdata : 32'h0;
                    end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                        state_q       <= ST_DONE;
                        bus_req_o     <= 1'b0;
                        done_out      <= 1'b1;
                        bus_err_out   <= 1'b1;
                        load_data_out <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    done_out    <= 1'b0;
                    bus_err_out <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
                    misalign_q  <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (TIMEOUT_CYCLES = 4). Expected bus
// fields, latencies and load results come from a byte-lane arithmetic model.
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] addr_in = '0;
    logic [31:0] wdata_in = '0;
    logic        mem_write_in = 1'b0;
    logic        is_load_in = 1'b0;
    logic [2:0]  dm_type_in = '0;
    logic        stall_out;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_wstrb_o;
    logic [31:0] bus_rdata_i = '0;
    logic        bus_ack_i = 1'b0;
    logic [31:0] load_data_out;
    logic        done_out;
    logic        bus_err_out;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .addr_in       (addr_in),
        .wdata_in      (wdata_in),
        .mem_write_in  (mem_write_in),
        .is_load_in    (is_load_in),
        .dm_type_in    (dm_type_in),
        .stall_out     (stall_out),
        .bus_req_o     (bus_req_o),
        .bus_we_o      (bus_we_o),
        .bus_addr_o    (bus_addr_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_wstrb_o   (bus_wstrb_o),
        .bus_rdata_i   (bus_rdata_i),
        .bus_ack_i     (bus_ack_i),
        .load_data_out (load_data_out),
        .done_out      (done_out),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_out  (misalign_out),
`endif
        .bus_err_out   (bus_err_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---- reference model: access size in bytes and lane arithmetic ----
    function automatic int access_size(input logic [2:0] dm);
        if (dm == 3'd1 || dm == 3'd2) return 2;
        if (dm == 3'd3 || dm == 3'd4) return 1;
        return 4;
    endfunction

    function automatic int lane_off(input logic [31:0] a, input int sz);
        if (sz == 4) return 0;
        if (sz == 2) return int'(a & 32'h2);
        return int'(a & 32'h3);
    endfunction

    function automatic logic [3:0] model_strb(input logic [31:0] a, input logic [2:0] dm);
        int sz = access_size(dm);
        int m  = (1 << sz) - 1;
        return 4'((m << lane_off(a, sz)) & 15);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] w, input logic [2:0] dm);
        logic [31:0] r;
        int sz = access_size(dm);
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                               input logic [2:0] dm);
        int sz = access_size(dm);
        logic [31:0] mask, v;
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 1);
        v = (rd >> (8*lane_off(a, sz))) & mask;
        if ((dm == 3'd1 || dm == 3'd3) && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bit model_misaligned(input logic [31:0] a, input logic [2:0] dm);
`ifdef MEM_MISALIGN_TRAP_EN
        int sz = access_size(dm);
        return (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
`else
        return (a == 32'hFFFF_FFFF) && (dm == 3'd7) && 1'b0;
`endif
    endfunction

    // ack_at: BUSY cycle (1-based) that carries the ack; 0 or >TMO means none.
    task automatic do_access(input string nm, input bit v, input logic [31:0] a,
                             input logic [31:0] w, input bit we, input bit ld,
                             input logic [2:0] dm, input int ack_at,
                             input logic [31:0] rd);
        bit is_acc = v && (we || ld);
        bit is_ld  = is_acc && !we;
        bit mis    = is_acc && model_misaligned(a, dm);
        bit acked  = (ack_at >= 1 && ack_at <= TMO);
        int exp_busy = mis ? 0 : (acked ? ack_at : TMO);
        int busy = 0, stalls = 0;
        bit seen_done = 0, fields_done = 0;

        @(posedge clk); #1;
        in_valid = v; addr_in = a; wdata_in = w; mem_write_in = we;
        is_load_in = ld; dm_type_in = dm;

        if (!is_acc) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                chk({nm, " idle_stall"}, 32'(stall_out), 32'd0);
                chk({nm, " idle_req"},   32'(bus_req_o), 32'd0);
                chk({nm, " idle_done"},  32'(done_out),  32'd0);
                bus_ack_i = 1'b1;
                @(posedge clk); #1 bus_ack_i = 1'b0;
            end
            return;
        end

        for (int c = 0; c < 20 && !seen_done; c++) begin
            @(negedge clk);
            if (c == 0) chk({nm, " done_pulse_width"}, 32'(done_out), 32'd0);
            if (done_out) begin
                seen_done = 1;
                chk({nm, " done_stall"}, 32'(stall_out), 32'd0);
                chk({nm, " done_req"},   32'(bus_req_o), 32'd0);
                chk({nm, " bus_err"},    32'(bus_err_out), 32'(!mis && !acked));
                if (is_ld || mis)
                    chk({nm, " load_data"}, load_data_out,
                        (mis || !acked) ? 32'h0 : model_load(rd, a, dm));
`ifdef MEM_MISALIGN_TRAP_EN
                chk({nm, " misalign"}, 32'(misalign_out), 32'(mis));
`endif
            end else begin
                if (stall_out) stalls++;
                if (bus_req_o) begin
                    busy++;
                    if (!fields_done) begin
                        fields_done = 1;
                        chk({nm, " bus_addr"}, bus_addr_o, a & 32'hFFFF_FFFC);
                        chk({nm, " bus_we"},   32'(bus_we_o), 32'(we));
                        chk({nm, " bus_strb"}, 32'(bus_wstrb_o), 32'(model_strb(a, dm)));
                        if (we) chk({nm, " bus_wdata"}, bus_wdata_o, model_wdata(w, dm));
                    end
                    if (busy == ack_at) begin
                        bus_ack_i = 1'b1; bus_rdata_i = rd;
                    end
                end
                @(posedge clk); #1;
                bus_ack_i = 1'b0; bus_rdata_i = $urandom;
            end
        end
        chk({nm, " done_seen"},   32'(seen_done), 32'd1);
        chk({nm, " busy_cycles"}, 32'(busy), 32'(exp_busy));
        chk({nm, " stall_cycles"}, 32'(stalls), 32'(1 + exp_busy));
    endtask

    initial begin
        // reset state
        #12;
        @(negedge clk);
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_req",   32'(bus_req_o), 32'd0);
        chk("rst_done",  32'(done_out), 32'd0);
        chk("rst_err",   32'(bus_err_out), 32'd0);
        chk("rst_ldata", load_data_out, 32'd0);
        chk("rst_addr",  bus_addr_o, 32'd0);
        rst = 1'b1;

        // directed
        do_access("sw",      1, 32'h1004, 32'hDEADBEEF, 1, 0, 3'd0, 2, 32'h0);
        do_access("sb",      1, 32'h2003, 32'h000000A5, 1, 0, 3'd3, 1, 32'h0);
        do_access("sh_hi",   1, 32'h2002, 32'h0000BEEF, 1, 0, 3'd1, 1, 32'h0);
        do_access("lb",      1, 32'h3001, 32'h0, 0, 1, 3'd3, 1, 32'h12348056);
        do_access("lhu",     1, 32'h3002, 32'h0, 0, 1, 3'd2, 3, 32'h12348056);
        do_access("lh_neg",  1, 32'h3000, 32'h0, 0, 1, 3'd1, 1, 32'h0000F00D);
        do_access("lbu",     1, 32'h3003, 32'h0, 0, 1, 3'd4, 2, 32'h92345678);
        do_access("tmo",     1, 32'h3100, 32'h0, 0, 1, 3'd0, 0, 32'h0);
        do_access("ack_last",1, 32'h3104, 32'h0, 0, 1, 3'd0, TMO, 32'hCAFEF00D);
        do_access("both",    1, 32'h3200, 32'h11223344, 1, 1, 3'd0, 1, 32'h0);
        do_access("bubble",  0, 32'h3300, 32'h0, 1, 1, 3'd0, 1, 32'h0);
        do_access("nonmem",  1, 32'h3300, 32'h0, 0, 0, 3'd0, 1, 32'h0);
        do_access("lw_mis",  1, 32'h4002, 32'h0, 0, 1, 3'd0, 1, 32'h55667788);

        // reset during BUSY
        @(posedge clk); #1;
        in_valid = 1; addr_in = 32'h5000; mem_write_in = 0; is_load_in = 1; dm_type_in = 3'd0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("pre_rst_req", 32'(bus_req_o), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_req",   32'(bus_req_o), 32'd0);
        chk("mid_rst_stall", 32'(stall_out), 32'd0);
        chk("mid_rst_done",  32'(done_out), 32'd0);
        in_valid = 0;
        @(negedge clk);
        chk("held_rst_done", 32'(done_out), 32'd0);
        #2 rst = 1'b1;
        do_access("post_rst_ld", 1, 32'h5004, 32'h0, 0, 1, 3'd1, 1, 32'h80000001);
        do_access("b2b_ld",      1, 32'h5006, 32'h0, 0, 1, 3'd1, 1, 32'h8001ABCD);
        do_access("b2b_st",      1, 32'h5008, 32'h0BADF00D, 1, 0, 3'd0, 1, 32'h0);

        // randomized
        for (int i = 0; i < 150; i++) begin
            do_access("rnd", $urandom_range(0, 9) != 0, $urandom, $urandom,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      3'($urandom_range(0, 7)), $urandom_range(0, TMO + 1), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
